instr_fetch: RTL

- Instruction fetch sequencer between the program counter and decode.
- Holds its own 24-bit fetch pointer and issues single-outstanding reads to instruction memory over a req/ack handshake.
- Buffers returned words with their addresses in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects, flushes stale state and drops any in-flight response.

---
 rtl/instr_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding fetch sequencer feeding a DEPTH-entry buffer; mem_ack -> ir_valid in 1 cycle,
// fetching pauses while the buffer is full. Define IFETCH_STALL_CNT_EN to build the memory stall counter.
module instr_fetch #(
  parameter int                ADDR_W     = 24,
  parameter int                INSTR_W    = 32,
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  output logic [15:0]        stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_post;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [INSTR_W-1:0] buf_dat_q [DEPTH];
  logic [INSTR_W-1:0] buf_dat_d [DEPTH];
  logic [ADDR_W-1:0]  buf_pc_q  [DEPTH];
  logic [ADDR_W-1:0]  buf_pc_d  [DEPTH];
  logic               push, pop;

  assign mem_req  = (state_q == S_FETCH) || (state_q == S_FLUSH);
  assign mem_addr = mem_addr_q;
  assign ir_valid = (cnt_q != '0);
  assign ir       = buf_dat_q[rd_ptr_q];
  assign ir_pc    = buf_pc_q[rd_ptr_q];

  always_comb begin
    pop         = ir_valid && ir_ready;
    push        = (state_q == S_FETCH) && mem_ack && !redirect;
    cnt_post    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    cnt_d       = cnt_post;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_dat_d   = buf_dat_q;
    buf_pc_d    = buf_pc_q;

    if (push) begin
      buf_dat_d[wr_ptr_q] = mem_data;
      buf_pc_d[wr_ptr_q]  = fetch_ptr_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      fetch_ptr_d         = fetch_ptr_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (push && (cnt_post == CNT_W'(DEPTH))) state_d = S_WAIT;
      S_WAIT:  if (cnt_post < CNT_W'(DEPTH)) state_d = S_FETCH;
      S_FLUSH: if (mem_ack) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // An unacked request cannot be withdrawn, so it is drained in FLUSH and its data dropped.
    if (redirect) begin
      fetch_ptr_d = redirect_addr;
      cnt_d       = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      if (mem_req && !mem_ack) state_d = S_FLUSH;
      else                     state_d = S_FETCH;
    end

    mem_addr_d = (state_d == S_FLUSH) ? mem_addr_q : fetch_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_ptr_q <= RESET_ADDR;
      mem_addr_q  <= RESET_ADDR;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      buf_dat_q   <= '{default: '0};
      buf_pc_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_dat_q   <= buf_dat_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mem_req && !mem_ack && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
